// File: rtl/gcd_seq.sv
// rtl/gcd_seq.sv - parametrised subtractive GCD engine with go/busy/done handshake
//
// Purpose:
//   Computes gcd(X, Y) by repeated subtraction, one step per clock.
//   The engine also reports how many subtract steps the result took.
//   gcd(0,0)=0, gcd(0,y)=y and gcd(x,0)=x fall out of the zero checks.
//
// Ports:
//   clk   in   1      rising-edge clock
//   rst   in   1      synchronous active-high reset
//   go    in   1      start request, honoured only when idle
//   X     in   WIDTH  operand A, captured with go
//   Y     in   WIDTH  operand B, captured with go
//   busy  out  1      high whenever the engine is not idle
//   done  out  1      one-cycle pulse when GCD/ITER hold a new result
//   GCD   out  WIDTH  last result, held until the next result
//   ITER  out  WIDTH  subtract steps taken for the last result
//
// WIDTH must lie in 2..64. The step counter cannot wrap. The worst case is
// (2^WIDTH-1, 1), which takes 2^WIDTH-2 steps.

module gcd_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] GCD,
  output logic [WIDTH-1:0] ITER
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] cnt;

  // busy and done are registered alongside the state register. They never
  // depend combinationally on go.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      a     <= ZERO;
      b     <= ZERO;
      cnt   <= ZERO;
      GCD   <= ZERO;
      ITER  <= ZERO;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (go) begin
            a     <= X;
            b     <= Y;
            cnt   <= ZERO;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end

        ST_RUN: begin
          // The zero checks come first, so a zero operand finishes without
          // a subtract step. The equality check then stops the loop when
          // both operands are equal.
          if (a == ZERO) begin
            GCD   <= b;
            ITER  <= cnt;
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (b == ZERO) begin
            GCD   <= a;
            ITER  <= cnt;
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (a == b) begin
            GCD   <= a;
            ITER  <= cnt;
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (a > b) begin
            // The larger operand is always the minuend, so this cannot underflow.
            a   <= a - b;
            cnt <= cnt + ONE;
          end else begin
            b   <= b - a;
            cnt <= cnt + ONE;
          end
        end

        ST_DONE: begin
          // This is the single cycle in which done is high. Leave
          // unconditionally, so a go held high waits one idle cycle.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_seq.sv
// tb/tb_gcd_seq.sv - directed self-checking bench for gcd_seq (32-bit and 8-bit instances)

module tb_gcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        go32 = 1'b0;
  logic [31:0] x32 = '0;
  logic [31:0] y32 = '0;
  logic        busy32;
  logic        done32;
  logic [31:0] gcd32;
  logic [31:0] iter32;

  logic        go8 = 1'b0;
  logic [7:0]  x8 = '0;
  logic [7:0]  y8 = '0;
  logic        busy8;
  logic        done8;
  logic [7:0]  gcd8;
  logic [7:0]  iter8;

  int tests = 0;
  int fails = 0;
  int dcnt32 = 0;
  int dcnt8 = 0;

  gcd_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .go(go32), .X(x32), .Y(y32),
    .busy(busy32), .done(done32), .GCD(gcd32), .ITER(iter32)
  );

  gcd_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .go(go8), .X(x8), .Y(y8),
    .busy(busy8), .done(done8), .GCD(gcd8), .ITER(iter8)
  );

  always #5 clk = ~clk;

  // done is high for a full cycle, so each pulse covers exactly one negedge.
  always @(negedge clk) begin
    if (done32) dcnt32++;
    if (done8)  dcnt8++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for done on dut32 and return the number of edges it took.
  task automatic wait_done32(output int n, output logic seen);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 1000) begin
      step();
      n++;
      if (done32) seen = 1'b1;
    end
  endtask

  task automatic run32(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input int exp_n, input logic [31:0] exp_g, input logic [31:0] exp_i);
    int   n;
    logic seen;
    x32 = x; y32 = y; go32 = 1'b1;
    step();
    go32 = 1'b0;
    chk({tag, "_busy_rise"}, busy32, 1);
    wait_done32(n, seen);
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_latency"}, n, exp_n);
    chk({tag, "_gcd"}, gcd32, exp_g);
    chk({tag, "_iter"}, iter32, exp_i);
    step();
    chk({tag, "_done_drop"}, done32, 0);
    chk({tag, "_busy_fall"}, busy32, 0);
  endtask

  initial begin
    int   n;
    int   d0;
    logic seen;
    logic [31:0] exp_a [4];
    logic [31:0] exp_b [4];

    // The reset lasts 3 cycles with go held high on both instances.
    rst = 1'b1; go32 = 1'b1; go8 = 1'b1; x32 = 32'd10; y32 = 32'd4;
    repeat (3) step();
    chk("rst_busy", busy32, 0);
    chk("rst_done", done32, 0);
    chk("rst_gcd", gcd32, 0);
    chk("rst_iter", iter32, 0);
    chk("rst_busy8", busy8, 0);
    rst = 1'b0; go32 = 1'b0; go8 = 1'b0;
    step();
    chk("rst_go_not_queued", busy32, 0);

    // The basic case 48,18 also checks the (a,b) trajectory.
    exp_a = '{32'd30, 32'd12, 32'd12, 32'd6};
    exp_b = '{32'd18, 32'd18, 32'd6, 32'd6};
    x32 = 32'd48; y32 = 32'd18; go32 = 1'b1;
    step();
    go32 = 1'b0; x32 = 32'd999; y32 = 32'd3;
    chk("basic_busy_rise", busy32, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("basic_a%0d", i + 1), dut32.a, exp_a[i]);
      chk($sformatf("basic_b%0d", i + 1), dut32.b, exp_b[i]);
      chk($sformatf("basic_nodone%0d", i + 1), done32, 0);
    end
    step();
    chk("basic_done_e5", done32, 1);
    chk("basic_gcd", gcd32, 6);
    chk("basic_iter", iter32, 4);
    step();
    chk("basic_done_drop", done32, 0);
    chk("basic_busy_fall", busy32, 0);
    chk("basic_gcd_hold", gcd32, 6);

    // Zero and equal operands
    run32("z00", 32'd0, 32'd0, 1, 32'd0, 32'd0);
    run32("z07", 32'd0, 32'd7, 1, 32'd7, 32'd0);
    run32("z90", 32'd9, 32'd0, 1, 32'd9, 32'd0);
    run32("eq55", 32'd5, 32'd5, 1, 32'd5, 32'd0);

    // Coprime case with go held high throughout
    d0 = dcnt32;
    x32 = 32'd17; y32 = 32'd5; go32 = 1'b1;
    step();
    wait_done32(n, seen);
    chk("hold_done_seen", seen, 1);
    chk("hold_latency", n, 7);
    chk("hold_gcd", gcd32, 1);
    chk("hold_iter", iter32, 6);
    step();
    chk("hold_idle_e8", busy32, 0);
    step();
    chk("hold_reaccept_e9", busy32, 1);
    go32 = 1'b0;
    wait_done32(n, seen);
    chk("hold2_latency", n, 7);
    step();
    chk("hold_done_count", dcnt32 - d0, 2);

    // Worst case on the 8-bit instance
    d0 = dcnt8;
    x8 = 8'd255; y8 = 8'd1; go8 = 1'b1;
    step();
    go8 = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 1000) begin
      step();
      n++;
      if (done8) seen = 1'b1;
    end
    chk("w8_done_seen", seen, 1);
    chk("w8_latency", n, 255);
    chk("w8_gcd", gcd8, 1);
    chk("w8_iter", iter8, 254);
    step();
    chk("w8_busy_fall", busy8, 0);
    chk("w8_done_count", dcnt8 - d0, 1);

    // Abort: reset is sampled at E2.
    d0 = dcnt32;
    x32 = 32'd48; y32 = 32'd18; go32 = 1'b1;
    step();
    go32 = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("abort_busy", busy32, 0);
    chk("abort_done", done32, 0);
    chk("abort_gcd", gcd32, 0);
    chk("abort_iter", iter32, 0);
    rst = 1'b0;
    repeat (10) step();
    chk("abort_no_done", dcnt32 - d0, 0);
    run32("after_abort", 32'd12, 32'd8, 3, 32'd4, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
